// File: rtl/memory_stage_if.sv
// Data memory request/done bus between the MEM stage and the data memory.
// The stage is the master; the memory model or controller is the slave.
interface memory_stage_if;
  logic [15:0] dmAddr;
  logic [15:0] dmDataIn;
  logic        dmRd;
  logic        dmWr;
  logic [15:0] dmDataOut;
  logic        dmDone;
  logic        dmErr;

  modport master (
    output dmAddr,
    output dmDataIn,
    output dmRd,
    output dmWr,
    input  dmDataOut,
    input  dmDone,
    input  dmErr
  );

  modport slave (
    input  dmAddr,
    input  dmDataIn,
    input  dmRd,
    input  dmWr,
    output dmDataOut,
    output dmDone,
    output dmErr
  );
endinterface

// File: rtl/memory_stage.sv
// MEM stage: load/store against a stall-capable data memory and the MEM/WB
// register; stalls upstream while an access is outstanding.
module memory_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] aluOut_i,
  input  logic [15:0] reg2Data_i,
  input  logic        memEn_i,
  input  logic        memWrt_i,
  input  logic        regWrt_i,
  input  logic        halt_i,
  input  logic        err_i,
  input  logic [2:0]  writeReg_i,
  input  logic [2:0]  regWrtSrc_i,
  input  logic [15:0] nextPc_i,
  input  logic [15:0] setVal_i,
  memory_stage_if.master dm,
  output logic        memStall_o,
  output logic [15:0] memDataOut_o,
  output logic [15:0] aluOutOut_o,
  output logic [15:0] nextPcOut_o,
  output logic [15:0] setValOut_o,
  output logic        regWrtOut_o,
  output logic        haltOut_o,
  output logic        errOut_o,
  output logic [2:0]  writeRegOut_o,
  output logic [2:0]  regWrtSrcOut_o
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [15:0] addr_q;
  logic [15:0] data_q;
  logic        wr_q;

  logic is_idle;
  logic is_wait;
  logic misal;
  logic req;
  logic tmo;
  logic done;
  logic dir;
  logic retire;

  assign is_idle = (state_q == IDLE);
  assign is_wait = (state_q == WAIT);

  // rst gates the Mealy terms so reset forces every output low.
  assign misal = rst & is_idle & memEn_i & aluOut_i[0];
  assign req   = rst & is_idle & memEn_i & ~aluOut_i[0];
  assign tmo   = is_wait & ~dm.dmDone & (cnt_q == CNT_LAST);
  assign done  = dm.dmDone & (req | is_wait);
  assign dir   = is_wait ? wr_q : memWrt_i;

  assign dm.dmRd     = req & ~memWrt_i;
  assign dm.dmWr     = req & memWrt_i;
  assign dm.dmAddr   = is_wait ? addr_q :
                       (req ? aluOut_i : 16'h0000);
  assign dm.dmDataIn = is_wait ? data_q :
                       (req ? reg2Data_i : 16'h0000);

  assign memStall_o = rst & (req | is_wait) & ~dm.dmDone & ~tmo;

  always_comb begin
    retire = 1'b0;
    unique case (1'b1)
      is_wait: retire = dm.dmDone | tmo;
      is_idle: retire = ~(req & ~dm.dmDone);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      addr_q         <= 16'h0000;
      data_q         <= 16'h0000;
      wr_q           <= 1'b0;
      memDataOut_o   <= 16'h0000;
      aluOutOut_o    <= 16'h0000;
      nextPcOut_o    <= 16'h0000;
      setValOut_o    <= 16'h0000;
      regWrtOut_o    <= 1'b0;
      haltOut_o      <= 1'b0;
      errOut_o       <= 1'b0;
      writeRegOut_o  <= 3'd0;
      regWrtSrcOut_o <= 3'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req && !dm.dmDone) begin
            state_q <= WAIT;
            cnt_q   <= 8'd0;
            addr_q  <= aluOut_i;
            data_q  <= reg2Data_i;
            wr_q    <= memWrt_i;
          end
        end
        WAIT: begin
          if (dm.dmDone || tmo) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
      endcase

      // EX/MEM is held stable during WAIT, so its fields are still valid.
      if (retire) begin
        aluOutOut_o    <= aluOut_i;
        nextPcOut_o    <= nextPc_i;
        setValOut_o    <= setVal_i;
        writeRegOut_o  <= writeReg_i;
        regWrtSrcOut_o <= regWrtSrc_i;
        haltOut_o      <= halt_i;
        regWrtOut_o    <= regWrt_i & ~(misal | tmo);
        errOut_o       <= err_i | (done & dm.dmErr) | misal | tmo;
        if (done && !dir) begin
          memDataOut_o <= dm.dmDataOut;
        end
      end else begin
        regWrtOut_o <= 1'b0;
        haltOut_o   <= 1'b0;
        errOut_o    <= 1'b0;
      end
    end
  end

endmodule
